// File: rtl/act_lut_pkg.sv
// Shared widths, table depth and types for the activation LUT writer and its reader.
package act_lut_pkg;

    localparam int LUT_ADDR_W  = 4;
    localparam int LUT_DATA_W  = 8;
    localparam int LUT_ENTRIES = (1 << LUT_ADDR_W) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2
    } lut_state_t;

    typedef logic signed [LUT_DATA_W-1:0] lut_entry_t;

endpackage

// File: rtl/act_lut_loader_if.sv
// Load stream, status and read-port bundle between the config bus side and the LUT writer.
interface act_lut_loader_if import act_lut_pkg::*; #(
    parameter int ADDR_W = LUT_ADDR_W,
    parameter int DATA_W = LUT_DATA_W
);

    logic              load_start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              busy;
    logic              loaded;
    logic              error;
    logic [ADDR_W-1:0] rd_address;
    logic [DATA_W-1:0] rd_base;
    logic [DATA_W-1:0] rd_next;

    modport slave (
        input  load_start, in_valid, in_data, rd_address,
        output in_ready, busy, loaded, error, rd_base, rd_next
    );

    modport master (
        output load_start, in_valid, in_data, rd_address,
        input  in_ready, busy, loaded, error, rd_base, rd_next
    );

endinterface

// File: rtl/act_lut_regfile.sv
// LUT storage: one write port, and a zero-latency pair read of entry[a] and entry[a+1].
module act_lut_regfile import act_lut_pkg::*; #(
    parameter int ADDR_W = LUT_ADDR_W,
    parameter int DATA_W = LUT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W:0]   waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rbase_o,
    output logic [DATA_W-1:0] rnext_o
);

    localparam int ENTRIES = (1 << ADDR_W) + 1;
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(ENTRIES - 1);

    logic [DATA_W-1:0] mem_q [ENTRIES];
    logic [ADDR_W:0]   rbase_idx_s;
    logic [ADDR_W:0]   rnext_idx_s;

    // Table registers; out-of-range write addresses are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i <= LAST_IDX)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // a+1 is formed one bit wider so address 15 reaches the 17th entry.
    assign rbase_idx_s = {1'b0, raddr_i};
    assign rnext_idx_s = rbase_idx_s + {{ADDR_W{1'b0}}, 1'b1};
    assign rbase_o     = mem_q[rbase_idx_s];
    assign rnext_o     = mem_q[rnext_idx_s];

endmodule

// File: rtl/act_lut_loader.sv
// Activation LUT writer: fills the table from a byte stream and verifies a trailing checksum.
module act_lut_loader import act_lut_pkg::*; #(
    parameter int ADDR_W = LUT_ADDR_W,
    parameter int DATA_W = LUT_DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    act_lut_loader_if.slave  bus
);

    localparam int ENTRIES = (1 << ADDR_W) + 1;
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(ENTRIES - 1);

    lut_state_t        state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              loaded_q, loaded_d;
    logic              error_q, error_d;
    logic              busy_q;
    logic              in_ready_s;
    logic              beat_s;
    logic              we_s;

    // Next-state, counter, checksum and write-enable decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        loaded_d   = loaded_q;
        error_d    = error_q;
        we_s       = 1'b0;
        in_ready_s = (state_q != IDLE) && !bus.load_start;
        beat_s     = in_ready_s && bus.in_valid;

        // load_start wins in every state, so a restart never accepts a beat.
        if (bus.load_start) begin
            state_d  = LOAD;
            cnt_d    = '0;
            sum_d    = '0;
            loaded_d = 1'b0;
            error_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                LOAD: begin
                    if (beat_s) begin
                        we_s  = 1'b1;
                        sum_d = sum_q + bus.in_data;
                        cnt_d = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
                        if (cnt_q == LAST_IDX) begin
                            state_d = CHECK;
                        end else begin
                            state_d = LOAD;
                        end
                    end else begin
                        state_d = LOAD;
                    end
                end
                CHECK: begin
                    if (beat_s) begin
                        state_d = IDLE;
                        if (bus.in_data == sum_q) begin
                            loaded_d = 1'b1;
                        end else begin
                            error_d = 1'b1;
                        end
                    end else begin
                        state_d = CHECK;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, counter, accumulator and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sum_q    <= '0;
            loaded_q <= 1'b0;
            error_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            loaded_q <= loaded_d;
            error_q  <= error_d;
            busy_q   <= (state_d != IDLE);
        end
    end

    act_lut_regfile #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we_s),
        .waddr_i (cnt_q),
        .wdata_i (bus.in_data),
        .raddr_i (bus.rd_address),
        .rbase_o (bus.rd_base),
        .rnext_o (bus.rd_next)
    );

    assign bus.in_ready = in_ready_s;
    assign bus.busy     = busy_q;
    assign bus.loaded   = loaded_q;
    assign bus.error    = error_q;

endmodule

// File: tb/tb_act_lut_loader.sv
// Scoreboard bench for act_lut_loader: random and directed loads against a table/checksum model.
module tb_act_lut_loader;
    import act_lut_pkg::*;

    typedef struct packed {
        logic loaded;
        logic error;
    } done_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    act_lut_loader_if bus();

    act_lut_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  model_tab [17];
    logic [7:0]  stim [17];
    int          beats = 0;
    int          msum  = 0;
    done_t       done_q [$];
    logic [15:0] rd_q [$];
    logic        rd_req = 1'b0;
    logic        busy_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: read-port checks on request, completion checks whenever busy falls.
    always @(negedge clk) begin
        logic [15:0] er;
        done_t       ed;
        if (rd_req) begin
            if (rd_q.size() == 0) begin
                chk("rd_queue_empty", 1, 0);
            end else begin
                er = rd_q.pop_front();
                chk("rd_base", int'(bus.rd_base), int'(er[15:8]));
                chk("rd_next", int'(bus.rd_next), int'(er[7:0]));
            end
        end
        if (busy_prev && !bus.busy) begin
            if (done_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                ed = done_q.pop_front();
                chk("done_loaded", int'(bus.loaded), int'(ed.loaded));
                chk("done_error", int'(bus.error), int'(ed.error));
            end
        end
        busy_prev <= bus.busy;
    end

    task automatic pulse_start();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        beats = 0;
        msum  = 0;
    endtask

    task automatic send_beat(input logic [7:0] d, input bit gaps);
        bit acc;
        int guard;
        if (gaps) begin
            for (int g = 0; g < 8 && $urandom_range(0, 1) == 1; g++) tick();
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 64) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            chk("beat_accept_timeout", 0, 1);
        end else begin
            if (beats < 17) begin
                model_tab[beats] = d;
                msum = (msum + int'(d)) % 256;
            end
            beats++;
        end
    endtask

    task automatic stream_all(input bit corrupt, input bit gaps);
        done_t ed;
        logic [7:0] cks;
        for (int i = 0; i < 17; i++) send_beat(stim[i], gaps);
        cks = 8'(msum + (corrupt ? 1 : 0));
        ed.loaded = !corrupt;
        ed.error  = corrupt;
        done_q.push_back(ed);
        send_beat(cks, gaps);
    endtask

    task automatic sweep();
        for (int a = 0; a < 16; a++) begin
            bus.rd_address = 4'(a);
            rd_q.push_back({model_tab[a], model_tab[a+1]});
            rd_req = 1'b1;
            tick();
        end
        rd_req = 1'b0;
    endtask

    task automatic ramp_stim();
        for (int i = 0; i < 17; i++) stim[i] = 8'(16 * i - 128);
    endtask

    initial begin
        done_t ed;
        int    guard;
        bus.load_start = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = 8'h00;
        bus.rd_address = 4'h0;
        for (int i = 0; i < 17; i++) model_tab[i] = 8'h00;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_loaded", int'(bus.loaded), 0);
        chk("rst_error", int'(bus.error), 0);
        tick();
        bus.in_valid = 1'b0;
        sweep();

        // 1: ramp, good checksum
        ramp_stim();
        pulse_start();
        stream_all(1'b0, 1'b0);
        tick();
        sweep();

        // 2: ramp, bad checksum, then FSM idle
        pulse_start();
        stream_all(1'b1, 1'b0);
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("bad_idle_in_ready", int'(bus.in_ready), 0);
        chk("bad_busy", int'(bus.busy), 0);
        chk("bad_loaded", int'(bus.loaded), 0);
        chk("bad_error", int'(bus.error), 1);
        tick();
        bus.in_valid = 1'b0;

        // 3: restart after the 9th beat
        pulse_start();
        for (int i = 0; i < 9; i++) send_beat(stim[i], 1'b0);
        bus.load_start = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_data    = 8'h5A;
        @(negedge clk);
        chk("restart_in_ready", int'(bus.in_ready), 0);
        tick();
        bus.load_start = 1'b0;
        bus.in_valid   = 1'b0;
        beats = 0;
        msum  = 0;
        for (int i = 0; i < 17; i++) stim[i] = 8'($urandom_range(0, 255));
        stream_all(1'b0, 1'b0);
        tick();
        sweep();

        // 4: ramp with random valid gaps
        ramp_stim();
        pulse_start();
        stream_all(1'b0, 1'b1);
        tick();
        chk("gap_loaded", int'(bus.loaded), 1);
        sweep();

        // Random data loads, random checksum corruption
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 17; i++) stim[i] = 8'($urandom_range(0, 255));
            pulse_start();
            stream_all(1'($urandom_range(0, 1)), 1'b1);
            tick();
            sweep();
        end

        // 5: reset mid-load
        pulse_start();
        for (int i = 0; i < 5; i++) send_beat(stim[i], 1'b0);
        ed.loaded = 1'b0;
        ed.error  = 1'b0;
        done_q.push_back(ed);
        rst = 1'b1;
        #1;
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_loaded", int'(bus.loaded), 0);
        chk("midrst_error", int'(bus.error), 0);
        chk("midrst_in_ready", int'(bus.in_ready), 0);
        for (int i = 0; i < 17; i++) model_tab[i] = 8'h00;
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("postrst_in_ready", int'(bus.in_ready), 0);
            chk("postrst_busy", int'(bus.busy), 0);
            tick();
        end
        bus.in_valid = 1'b0;
        sweep();

        // 6: ramp, full pair sweep including address 15
        ramp_stim();
        pulse_start();
        stream_all(1'b0, 1'b1);
        tick();
        sweep();

        guard = 0;
        while ((done_q.size() != 0 || rd_q.size() != 0) && guard < 20) begin
            tick();
            guard++;
        end
        if (done_q.size() != 0 || rd_q.size() != 0) begin
            chk("scoreboard_drain", done_q.size() + rd_q.size(), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
